// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter movement blocks: OLED geometry,
// coordinate width, default sprite size and the motion/walk enums.
package fighter_pkg;

    localparam int OLED_W  = 96;
    localparam int OLED_H  = 64;
    localparam int COORD_W = 7;

    localparam int SPRITE_W_DEF = 16;
    localparam int SPRITE_H_DEF = 20;

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } motion_state_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_LEFT,
        DIR_RIGHT
    } walk_dir_e;

endpackage

// File: rtl/motion_x_clamp.sv
// Combinational horizontal step: applies one walk step, clamps to the
// screen, then limits the step so this sprite never walks into the
// opponent when the two overlap vertically.
module motion_x_clamp
    import fighter_pkg::*;
(
    input  logic [COORD_W-1:0] pos_x_i,
    input  walk_dir_e          dir_i,
    input  logic [COORD_W-1:0] step_i,
    input  logic [COORD_W-1:0] opp_x_i,
    input  logic               v_overlap_i,
    input  logic [COORD_W-1:0] screen_w_i,
    input  logic [COORD_W-1:0] sprite_w_i,
    output logic [COORD_W-1:0] nx_o
);

    // Two guard bits: one for the sign, one so opp_x+sprite_w cannot
    // overflow even for an off-screen opponent coordinate.
    localparam int XW = COORD_W + 2;

    logic signed [XW-1:0] cur_s;
    logic signed [XW-1:0] step_s;
    logic signed [XW-1:0] opp_s;
    logic signed [XW-1:0] spr_s;
    logic signed [XW-1:0] max_s;
    logic signed [XW-1:0] cand_s;
    logic signed [XW-1:0] lim_s;
    logic                 opp_right;

    assign cur_s     = $signed({2'b00, pos_x_i});
    assign step_s    = $signed({2'b00, step_i});
    assign opp_s     = $signed({2'b00, opp_x_i});
    assign spr_s     = $signed({2'b00, sprite_w_i});
    assign max_s     = $signed({2'b00, screen_w_i}) - spr_s;
    assign opp_right = (opp_x_i >= pos_x_i);

    // Candidate x: step, edge clamp, then body-block toward the opponent.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it holding its old value and no latch is inferred.
    always_comb begin
        cand_s = cur_s;
        lim_s  = '0;

        case (dir_i)
            DIR_RIGHT: cand_s = cur_s + step_s;
            DIR_LEFT:  cand_s = cur_s - step_s;
            default:   cand_s = cur_s;
        endcase

        if (cand_s < 0) begin
            cand_s = '0;
        end else if (cand_s > max_s) begin
            cand_s = max_s;
        end

        // The block only ever shortens a step toward the opponent; it is
        // bounded by the current x so it never pushes this sprite backward.
        // Already-overlapping sprites therefore cannot close in further.
        if (v_overlap_i && dir_i == DIR_RIGHT && opp_right) begin
            lim_s = opp_s - spr_s;
            if (cand_s > lim_s) cand_s = lim_s;
            if (cand_s < cur_s) cand_s = cur_s;
        end else if (v_overlap_i && dir_i == DIR_LEFT && !opp_right) begin
            lim_s = opp_s + spr_s;
            if (cand_s < lim_s) cand_s = lim_s;
            if (cand_s > cur_s) cand_s = cur_s;
        end
    end

    assign nx_o = cand_s[COORD_W-1:0];

endmodule

// File: rtl/fighter_motion.sv
// Per-player movement controller: walking, jump with gravity, screen
// clamp and body-block against the opponent. All state advances only on
// frame_tick; outputs are registered.
// Optional: define FIGHTER_AIR_CONTROL_EN to allow walking while airborne.
module fighter_motion
    import fighter_pkg::*;
#(
    parameter int START_X   = 10,
    parameter int GROUND_Y  = 40,
    parameter int SCREEN_W  = OLED_W,
    parameter int SPRITE_W  = SPRITE_W_DEF,
    parameter int SPRITE_H  = SPRITE_H_DEF,
    parameter int WALK_STEP = 2,
    parameter int JUMP_V    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_jump,
    input  logic [COORD_W-1:0] opp_x,
    input  logic [COORD_W-1:0] opp_y,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               airborne,
    output logic               landed
);

    // The jump apex must stay on screen.
    if (JUMP_V * (JUMP_V + 1) / 2 > GROUND_Y) begin : g_jump_too_high
        $error("fighter_motion: JUMP_V peak height exceeds GROUND_Y");
    end

    localparam logic [COORD_W-1:0] START_X_C   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] GROUND_Y_C  = COORD_W'(GROUND_Y);
    localparam logic [COORD_W:0]   GROUND_Y_W  = (COORD_W + 1)'(GROUND_Y);
    localparam logic [COORD_W-1:0] SCREEN_W_C  = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] SPRITE_W_C  = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] SPRITE_H_C  = COORD_W'(SPRITE_H);
    localparam logic [COORD_W-1:0] WALK_STEP_C = COORD_W'(WALK_STEP);
    localparam logic [COORD_W-1:0] JUMP_V_C    = COORD_W'(JUMP_V);

    motion_state_e      state_q, state_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic [COORD_W-1:0] vy_q, vy_d;
    logic               jump_req_q, jump_req_d;
    logic               btn_jump_q;
    logic               landed_q, landed_d;

    logic               jump_edge;
    logic [COORD_W-1:0] dy;
    logic               v_overlap;
    walk_dir_e          dir;
    logic [COORD_W-1:0] nx;
    logic [COORD_W:0]   y_sum;
    logic               touchdown;
    logic               move_ok;

    assign jump_edge = btn_jump & ~btn_jump_q;
    assign dy        = (pos_y_q >= opp_y) ? (pos_y_q - opp_y) : (opp_y - pos_y_q);
    assign v_overlap = (dy < SPRITE_H_C);

    // Left and right together cancel out.
    always_comb begin
        case ({btn_right, btn_left})
            2'b10:   dir = DIR_RIGHT;
            2'b01:   dir = DIR_LEFT;
            default: dir = DIR_NONE;
        endcase
    end

    motion_x_clamp u_x_clamp (
        .pos_x_i     (pos_x_q),
        .dir_i       (dir),
        .step_i      (WALK_STEP_C),
        .opp_x_i     (opp_x),
        .v_overlap_i (v_overlap),
        .screen_w_i  (SCREEN_W_C),
        .sprite_w_i  (SPRITE_W_C),
        .nx_o        (nx)
    );

    // Next-state: jump request latch, vertical FSM and horizontal update.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vy_d       = vy_q;
        landed_d   = 1'b0;
        touchdown  = 1'b0;
        y_sum      = '0;
        jump_req_d = jump_req_q | (jump_edge && state_q == GROUND);

        if (frame_tick) begin
            // A request lives for one frame only, used or not.
            jump_req_d = 1'b0;

            case (state_q)
                GROUND: begin
                    if (jump_req_q || jump_edge) begin
                        state_d = RISE;
                        vy_d    = JUMP_V_C;
                    end
                end
                RISE: begin
                    pos_y_d = (pos_y_q > vy_q) ? (pos_y_q - vy_q) : '0;
                    if (vy_q == COORD_W'(1)) begin
                        state_d = FALL;
                        vy_d    = '0;
                    end else begin
                        vy_d = vy_q - COORD_W'(1);
                    end
                end
                FALL: begin
                    vy_d  = (vy_q >= JUMP_V_C) ? JUMP_V_C : (vy_q + COORD_W'(1));
                    y_sum = {1'b0, pos_y_q} + {1'b0, vy_d};
                    if (y_sum >= GROUND_Y_W) begin
                        pos_y_d   = GROUND_Y_C;
                        vy_d      = '0;
                        state_d   = GROUND;
                        landed_d  = 1'b1;
                        touchdown = 1'b1;
                    end else begin
                        pos_y_d = y_sum[COORD_W-1:0];
                    end
                end
                default: begin
                    state_d = GROUND;
                    vy_d    = '0;
                end
            endcase

            if (move_ok) begin
                pos_x_d = nx;
            end
        end
    end

    // Walking is gated by the state at the sampling tick; x is held on the
    // touchdown tick in every build.
`ifdef FIGHTER_AIR_CONTROL_EN
    assign move_ok = !touchdown;
`else
    assign move_ok = (state_q == GROUND);
`endif

    // State registers; reset wins over everything, including a jump.
    // NOTE: rst_n is sampled only on the clock edge here (synchronous), and
    // all sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= GROUND;
            pos_x_q    <= START_X_C;
            pos_y_q    <= GROUND_Y_C;
            vy_q       <= '0;
            jump_req_q <= 1'b0;
            btn_jump_q <= 1'b0;
            landed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vy_q       <= vy_d;
            jump_req_q <= jump_req_d;
            btn_jump_q <= btn_jump;
            landed_q   <= landed_d;
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign airborne = (state_q != GROUND);
    assign landed   = landed_q;

endmodule
